bus_arbiter_n: RTL and testbench

Parametrised N-master bus arbiter and transfer controller for the shared address/data bus, the successor to the two-master fixed-priority control state machine. It accepts bus requests from `NUM_MASTERS` masters and grants one at a time. It sequences the address and data phases that steer the data path's address/data muxes, handles the slave response codes (OKAY/ERROR/RETRY/SPLIT) with split-master masking, and enforces a wait-state timeout.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_prio_pick.sv | 28 ++
 rtl/bus_arbiter_n.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter_n.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the N-master bus arbiter: slave response codes,
// FSM state encoding and the master-count legality check.
package bus_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ADDR  = 2'd2,
        ST_DATA  = 2'd3
    } bus_state_e;

    localparam int NUM_MASTERS_MIN = 2;
    localparam int NUM_MASTERS_MAX = 8;

    function automatic bit num_masters_ok(input int n);
        return (n >= NUM_MASTERS_MIN) && (n <= NUM_MASTERS_MAX);
    endfunction

endpackage

// File: rtl/bus_prio_pick.sv
// Combinational winner picker: first set bit of 'eligible' searching upward
// from 'ptr' and wrapping modulo NUM_MASTERS. ptr = 0 gives fixed priority.
module bus_prio_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] eligible,
    input  logic [MW-1:0]          ptr,
    output logic [MW-1:0]          winner,
    output logic                   valid
);

    // Scan from the lowest priority down so the highest-priority hit lands last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_MASTERS;
            if (eligible[idx]) begin
                winner = MW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter / transfer controller (IDLE->GRANT->ADDR->DATA).
// Define BUS_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module bus_arbiter_n
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int WAIT_MAX    = 16,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] busreq,
    input  logic [NUM_MASTERS-1:0] read_write,
    input  logic                   ready,
    input  logic [1:0]             response,
    input  logic [NUM_MASTERS-1:0] split_resume,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [MW-1:0]          master_sel,
    output logic                   aout,
    output logic                   dout_en,
    output logic                   write,
    output logic                   error,
    output logic                   timeout,
    output logic [NUM_MASTERS-1:0] split_mask
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    if (!num_masters_ok(NUM_MASTERS) || WAIT_MAX < 1) begin : g_bad_param
        $error("bus_arbiter_n: NUM_MASTERS must be 2..8 and WAIT_MAX >= 1");
    end

    bus_state_e             state_q, state_d;
    logic [CW-1:0]          wait_cnt, cnt_d;
    logic [NUM_MASTERS-1:0] split_set;
    logic                   load, err_d, tmo_d;
    logic [MW-1:0]          pick_idx, ptr;
    logic                   pick_vld;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [MW-1:0] rr_ptr;
    logic          data_done;

    // Pointer moves past any master leaving DATA for IDLE; RETRY stays in the loop.
    assign data_done = (state_q == ST_DATA) && (state_d == ST_IDLE);
    assign ptr       = rr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (data_done)
            rr_ptr <= (master_sel == MW'(NUM_MASTERS - 1)) ? '0 : master_sel + MW'(1);
    end
`else
    assign ptr = '0;
`endif

    bus_prio_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick (
        .eligible (busreq & ~split_mask),
        .ptr      (ptr),
        .winner   (pick_idx),
        .valid    (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = wait_cnt;
        load      = 1'b0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        split_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    load    = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = busreq[master_sel] ? ST_ADDR : ST_IDLE;
            ST_ADDR: begin
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ready) begin
                    case (response)
                        RESP_OKAY:  state_d = ST_IDLE;
                        RESP_ERROR: begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                        RESP_RETRY: state_d = ST_GRANT;
                        default: begin
                            split_set = NUM_MASTERS'(1) << master_sel;
                            state_d   = ST_IDLE;
                        end
                    endcase
                end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
                    // This edge samples the WAIT_MAX-th consecutive low cycle.
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = wait_cnt + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt   <= '0;
            master_sel <= '0;
            write      <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            split_mask <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= cnt_d;
            error    <= err_d;
            timeout  <= tmo_d;
            if (load) begin
                master_sel <= pick_idx;
                write      <= read_write[pick_idx];
            end
            // A SPLIT landing with a resume on the same bit keeps the master parked.
            split_mask <= (split_mask & ~split_resume) | split_set;
        end
    end

    assign grant   = (state_q != ST_IDLE) ? (NUM_MASTERS'(1) << master_sel) : '0;
    assign aout    = (state_q == ST_ADDR);
    assign dout_en = (state_q == ST_DATA);

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n (2 masters, WAIT_MAX = 4): reset, write,
// contention, SPLIT/resume, ERROR, timeout and mid-transfer reset.
module tb_bus_arbiter_n;
    import bus_pkg::*;

    logic       clk, rst;
    logic [1:0] busreq, read_write, split_resume, grant, split_mask, response;
    logic       ready, aout, dout_en, write, error, timeout;
    logic [0:0] master_sel;

    int checks   = 0;
    int failures = 0;
    int ngr;
    logic [1:0] gseq [3];
    int         gcyc [3];
    logic [1:0] prev_g;

    bus_arbiter_n #(.NUM_MASTERS(2), .WAIT_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .busreq       (busreq),
        .read_write   (read_write),
        .ready        (ready),
        .response     (response),
        .split_resume (split_resume),
        .grant        (grant),
        .master_sel   (master_sel),
        .aout         (aout),
        .dout_en      (dout_en),
        .write        (write),
        .error        (error),
        .timeout      (timeout),
        .split_mask   (split_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] all_out();
        return 32'({grant, master_sel, aout, dout_en, write, error, timeout, split_mask});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        busreq       = '0;
        read_write   = '0;
        ready        = 1'b0;
        response     = RESP_OKAY;
        split_resume = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outs", all_out(), 32'h0);
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant == 2'b00 && !aout && !dout_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_wait", 32'(ok), 32'h1);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_outs", all_out(), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", all_out(), 32'h0);
        end

        // Single write from master 0, zero wait states
        busreq = 2'b01; read_write = 2'b01; ready = 1'b1; response = RESP_OKAY;
        @(negedge clk);
        check("wr_grant", 32'(grant), 32'h1);
        check("wr_write", 32'(write), 32'h1);
        check("wr_aout_early", 32'(aout), 32'h0);
        @(negedge clk);
        check("wr_aout", 32'(aout), 32'h1);
        check("wr_grant_addr", 32'(grant), 32'h1);
        @(negedge clk);
        check("wr_dout_en", 32'(dout_en), 32'h1);
        check("wr_aout_off", 32'(aout), 32'h0);
        busreq = 2'b00;
        @(negedge clk);
        check("wr_idle_grant", 32'(grant), 32'h0);
        check("wr_idle_dout", 32'(dout_en), 32'h0);
        check("wr_no_error", 32'(error), 32'h0);

        // Contention, both masters requesting
        do_reset();
        busreq = 2'b11; ready = 1'b1; response = RESP_OKAY;
        ngr = 0; prev_g = 2'b00;
        for (int c = 0; c < 40 && ngr < 3; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev_g == 2'b00) begin
                gseq[ngr] = grant;
                gcyc[ngr] = c;
                ngr++;
            end
            prev_g = grant;
        end
        busreq = 2'b00;
        check("cont_count", 32'(ngr), 32'd3);
        check("cont_g0", 32'(gseq[0]), 32'h1);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        check("cont_g1", 32'(gseq[1]), 32'h2);
`else
        check("cont_g1", 32'(gseq[1]), 32'h1);
`endif
        check("cont_g2", 32'(gseq[2]), 32'h1);
        check("cont_gap1", 32'(gcyc[1] - gcyc[0]), 32'd4);
        check("cont_gap2", 32'(gcyc[2] - gcyc[1]), 32'd4);
        wait_idle();

        // SPLIT parks master 0; master 1 takes the bus
        do_reset();
        busreq = 2'b11; ready = 1'b1; response = RESP_SPLIT;
        @(negedge clk);
        check("sp_grant0", 32'(grant), 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("sp_dout", 32'(dout_en), 32'h1);
        @(negedge clk);
        check("sp_mask_set", 32'(split_mask), 32'h1);
        check("sp_released", 32'(grant), 32'h0);
        response = RESP_OKAY;
        @(negedge clk);
        check("sp_grant1", 32'(grant), 32'h2);
        split_resume = 2'b01;
        @(negedge clk);
        check("sp_mask_clr", 32'(split_mask), 32'h0);
        check("sp_m1_aout", 32'(aout), 32'h1);
        split_resume = 2'b00; busreq = 2'b10;
        @(negedge clk);
        check("sp_m1_dout", 32'(dout_en), 32'h1);
        response = RESP_SPLIT; split_resume = 2'b10;
        @(negedge clk);
        check("sp_set_wins", 32'(split_mask), 32'h2);
        busreq = 2'b00; response = RESP_OKAY; split_resume = 2'b10;
        @(negedge clk);
        check("sp_resume1", 32'(split_mask), 32'h0);
        split_resume = 2'b00;
        wait_idle();

        // ERROR response
        do_reset();
        busreq = 2'b01; ready = 1'b1; response = RESP_ERROR;
        repeat (3) @(negedge clk);
        busreq = 2'b00;
        @(negedge clk);
        check("er_error", 32'(error), 32'h1);
        check("er_no_tmo", 32'(timeout), 32'h0);
        check("er_grant", 32'(grant), 32'h0);
        @(negedge clk);
        check("er_pulse", 32'(error), 32'h0);

        // Wait-state timeout, read transfer
        do_reset();
        busreq = 2'b01; read_write = 2'b00; ready = 1'b0; response = RESP_OKAY;
        @(negedge clk);
        check("to_grant", 32'(grant), 32'h1);
        check("to_write", 32'(write), 32'h0);
        @(negedge clk);
        @(negedge clk);
        busreq = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("to_data", 32'({dout_en, error}), 32'h2);
        end
        @(negedge clk);
        check("to_err_tmo", 32'({error, timeout}), 32'h3);
        check("to_idle", 32'({grant, dout_en}), 32'h0);
        @(negedge clk);
        check("to_pulse", 32'({error, timeout}), 32'h0);

        // RETRY loop, then reset while in DATA
        do_reset();
        busreq = 2'b01; read_write = 2'b01; ready = 1'b1; response = RESP_RETRY;
        repeat (3) @(negedge clk);
        check("rt_dout", 32'(dout_en), 32'h1);
        @(negedge clk);
        check("rt_regrant", 32'({grant, aout, dout_en}), 32'h4);
        @(negedge clk);
        check("rt_aout", 32'(aout), 32'h1);
        @(negedge clk);
        check("rt_dout2", 32'(dout_en), 32'h1);
        #2 rst = 1'b0;
        #1 check("mid_rst_async", all_out(), 32'h0);
        @(negedge clk);
        response = RESP_OKAY;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'h1);
        check("post_rst_write", 32'(write), 32'h1);
        @(negedge clk);
        check("post_rst_aout", 32'(aout), 32'h1);
        busreq = 2'b00;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
